// File: rtl/mmult_opt_mdc_engine_fsm_if.sv
// Job-control and adapter ctrl/flags bundle for the mmult_opt_mdc engine FSM.
// master = engine FSM, slave = control slave plus kernel adapter.
interface mmult_opt_mdc_engine_fsm_if #(
  parameter int unsigned CNT_W = 16
);
  logic             job_start;
  logic [CNT_W-1:0] job_len;
  logic             busy;
  logic             job_done;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] done_cnt;
  logic             err;
  logic             start;
  logic             ready;
  logic             done;
  logic             idle;

  modport master (
    input  job_start, job_len, ready, done, idle,
    output start, busy, job_done, issued, done_cnt, err
  );

  modport slave (
    output job_start, job_len, ready, done, idle,
    input  start, busy, job_done, issued, done_cnt, err
  );
endinterface

// File: rtl/mmult_opt_mdc_engine_fsm.sv
// Engine-side job controller: issues one start per output element to the adapter,
// paced on ready, counts done pulses and reports job completion.
module mmult_opt_mdc_engine_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  mmult_opt_mdc_engine_fsm_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitReady, StDrain, StFinish} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic             err_q, err_d;
  logic             counting;

  assign counting = (state_q == StIssue) || (state_q == StWaitReady) || (state_q == StDrain);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    done_cnt_d = done_cnt_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.job_start) begin
          len_d      = bus_io.job_len;
          issued_d   = '0;
          done_cnt_d = '0;
          state_d    = (bus_io.job_len == '0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        issued_d = issued_q + CNT_W'(1);
        state_d  = (issued_d < len_q) ? StWaitReady : StDrain;
      end
      // ready is deliberately not looked at in StIssue: it may still be stale-high there
      StWaitReady: begin
        if (bus_io.ready) state_d = StIssue;
      end
      StDrain: begin
        if (done_cnt_q == len_q) state_d = StFinish;
      end
      StFinish: begin
        state_d = StIdle;
        if (!bus_io.idle) err_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (bus_io.done) begin
      if (counting && (done_cnt_q != len_q)) done_cnt_d = done_cnt_q + CNT_W'(1);
      else                                  err_d      = 1'b1;
    end

    // All results back while starts are still outstanding: adapter is out of step.
    if ((state_q == StWaitReady) && (done_cnt_d == len_q)) err_d = 1'b1;

    if (clear_i) begin
      state_d    = StIdle;
      len_d      = '0;
      issued_d   = '0;
      done_cnt_d = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      done_cnt_q <= done_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus_io.start    = (state_q == StIssue);
  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.job_done = (state_q == StFinish);
  assign bus_io.issued   = issued_q;
  assign bus_io.done_cnt = done_cnt_q;
  assign bus_io.err      = err_q;

endmodule

// File: tb/tb_mmult_opt_mdc_engine_fsm.sv
// Directed bench for mmult_opt_mdc_engine_fsm: adapter model with programmable
// ready/done latency, job expectations queued at launch and checked at job_done.
module tb_mmult_opt_mdc_engine_fsm;
  localparam int unsigned CNT_W = 16;

  typedef struct {
    int starts;
    int issued;
    int done_cnt;
    int err;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_ni  = 1'b0;
  logic clear_i = 1'b0;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   rq[$];
  int   dq[$];
  int   cyc        = 0;
  int   rdly       = 3;
  int   ddly       = 5;
  int   job_starts = 0;
  int   last_start = -1;
  int   gap_bad    = 0;
  int   jd_cnt     = 0;
  bit   pace_chk   = 1'b0;
  bit   ready_tie  = 1'b0;
  bit   man_done   = 1'b0;
  logic model_ready = 1'b0;
  logic model_done  = 1'b0;
  logic model_idle  = 1'b1;

  mmult_opt_mdc_engine_fsm_if #(.CNT_W(CNT_W)) bus ();

  assign bus.ready = model_ready | ready_tie;
  assign bus.done  = model_done | man_done;
  assign bus.idle  = model_idle;

  mmult_opt_mdc_engine_fsm #(.CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .bus_io (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Adapter model and job_done scoreboard, evaluated mid-cycle.
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    model_idle  <= (dq.size() == 0);
    model_ready <= 1'b0;
    model_done  <= 1'b0;
    if (rq.size() > 0 && rq[0] == cyc) begin
      model_ready <= 1'b1;
      void'(rq.pop_front());
    end
    if (dq.size() > 0 && dq[0] == cyc) begin
      model_done <= 1'b1;
      void'(dq.pop_front());
    end
    if (bus.start === 1'b1) begin
      job_starts++;
      if (pace_chk && last_start >= 0 && (cyc - last_start) != 2) gap_bad++;
      last_start = cyc;
      rq.push_back(cyc + rdly);
      dq.push_back(cyc + ddly);
    end
    if (bus.job_done === 1'b1) begin
      jd_cnt++;
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("job_starts", 32'(job_starts), 32'(e.starts));
        check("job_issued", 32'(bus.issued), 32'(e.issued));
        check("job_done_cnt", 32'(bus.done_cnt), 32'(e.done_cnt));
        check("job_err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic launch(input int len, input bit push, input int st, input int iss,
                        input int dc, input int er);
    exp_t e;
    e.starts   = st;
    e.issued   = iss;
    e.done_cnt = dc;
    e.err      = er;
    if (push) sb.push_back(e);
    job_starts    = 0;
    last_start    = -1;
    bus.job_start = 1'b1;
    bus.job_len   = CNT_W'(len);
    step(1);
    bus.job_start = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (job_starts < n && k < 200) begin
      step(1);
      k++;
    end
    check("starts_reached", 32'(job_starts), 32'(n));
  endtask

  task automatic wait_jobs(input int n);
    int k = 0;
    while (jd_cnt < n && k < 300) begin
      step(1);
      k++;
    end
    check("jobs_reached", 32'(jd_cnt), 32'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, 32'(bus.start), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_job_done"}, 32'(bus.job_done), 32'd0);
    check({tag, "_issued"}, 32'(bus.issued), 32'd0);
    check({tag, "_done_cnt"}, 32'(bus.done_cnt), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int k;
    bus.job_start = 1'b0;
    bus.job_len   = '0;

    step(2);
    check_all_zero("rst");
    rst_ni = 1'b1;
    step(1);

    // Reset while draining, then a normal len=1 job.
    ready_tie = 1'b1;
    ddly      = 30;
    launch(3, 1'b0, 0, 0, 0, 0);
    wait_starts(3);
    step(2);
    check("drain_busy", 32'(bus.busy), 32'd1);
    check("drain_issued", 32'(bus.issued), 32'd3);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midrst");
    rq.delete();
    dq.delete();
    sb.delete();
    step(1);
    rst_ni = 1'b1;
    ddly   = 3;
    step(1);
    launch(1, 1'b1, 1, 1, 1, 0);
    wait_jobs(1);

    // Nominal job with ready 3 and done 5 cycles after each start.
    ready_tie = 1'b0;
    rdly      = 3;
    ddly      = 5;
    launch(4, 1'b1, 4, 4, 4, 0);
    wait_jobs(2);
    step(3);
    check("nom_hold_issued", 32'(bus.issued), 32'd4);
    check("nom_hold_done_cnt", 32'(bus.done_cnt), 32'd4);
    check("nom_single_done", 32'(jd_cnt), 32'd2);

    // Back-to-back pacing with ready tied high.
    ready_tie = 1'b1;
    pace_chk  = 1'b1;
    launch(8, 1'b1, 8, 8, 8, 0);
    wait_jobs(3);
    pace_chk = 1'b0;
    check("b2b_gap_bad", 32'(gap_bad), 32'd0);
    step(2);

    // Zero-length job.
    launch(0, 1'b1, 0, 0, 0, 0);
    check("zero_busy", 32'(bus.busy), 32'd1);
    check("zero_job_done", 32'(bus.job_done), 32'd1);
    check("zero_start", 32'(bus.start), 32'd0);
    step(1);
    check("zero_busy_end", 32'(bus.busy), 32'd0);
    check("zero_job_done_end", 32'(bus.job_done), 32'd0);
    wait_jobs(4);
    step(1);

    // Protocol error: third done while done_cnt already equals len.
    ddly = 3;
    launch(2, 1'b1, 2, 2, 2, 1);
    k = 0;
    while (bus.done_cnt !== CNT_W'(2) && k < 100) begin
      step(1);
      k++;
    end
    check("perr_cnt_reached", 32'(bus.done_cnt), 32'd2);
    man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    wait_jobs(5);
    step(4);
    check("perr_sticky", 32'(bus.err), 32'd1);
    check("perr_done_cnt", 32'(bus.done_cnt), 32'd2);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("perr_cleared", 32'(bus.err), 32'd0);
    check("perr_clr_cnt", 32'(bus.done_cnt), 32'd0);
    step(1);

    // Clear after two starts, new job the very next cycle.
    ddly = 6;
    launch(5, 1'b0, 0, 0, 0, 0);
    wait_starts(2);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check_all_zero("clr");
    check("clr_starts", 32'(job_starts), 32'd2);
    rq.delete();
    dq.delete();
    launch(2, 1'b1, 2, 2, 2, 0);
    check("clr_accept_busy", 32'(bus.busy), 32'd1);
    wait_jobs(6);
    step(3);
    check("clr_no_extra_done", 32'(jd_cnt), 32'd6);
    check("final_err", 32'(bus.err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
